// File: rtl/branch_resolve.sv
// Stage-3 branch/jump resolver: evaluates the branch condition, drives the
// registered PC redirect into fetch, holds flush for FLUSH_CYCLES and writes the JAL link.
module branch_resolve #(
  parameter int unsigned         PC_WIDTH     = 16,
  parameter int unsigned         OFF_WIDTH    = 12,
  parameter logic [PC_WIDTH-1:0] PC_INITIAL   = '0,
  parameter int unsigned         FLUSH_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 RST,
  input  logic                 done_in,
  input  logic                 valid,
  input  logic [PC_WIDTH-1:0]  pc_in,
  input  logic [2:0]           br_type,
  input  logic [OFF_WIDTH-1:0] offset,
  input  logic [PC_WIDTH-1:0]  reg_target,
  input  logic                 flag_z,
  input  logic                 flag_n,
  output logic                 pc_chg,
  output logic [PC_WIDTH-1:0]  pc_out,
  output logic                 flush,
  output logic                 link_we,
  output logic [PC_WIDTH-1:0]  link_data,
  output logic                 done
);

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_JMP  = 3'd4,
    BR_JAL  = 3'd5,
    BR_JR   = 3'd6,
    BR_RSVD = 3'd7
  } br_e;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_e;

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic                pc_chg_q;
  logic [PC_WIDTH-1:0] pc_out_q;
  logic                flush_q;
  logic                link_we_q;
  logic [PC_WIDTH-1:0] link_data_q;
  logic                done_q;

  logic                accept;
  logic                taken;
  logic [PC_WIDTH-1:0] target;

  assign accept = done_in & valid & (state_q == IDLE);

  always_comb begin
    taken  = 1'b0;
    target = pc_in + PC_WIDTH'(signed'(offset));
    case (br_type)
      BR_BEQ:  taken = flag_z;
      BR_BNE:  taken = ~flag_z;
      BR_BLT:  taken = flag_n;
      BR_JMP:  taken = 1'b1;
      BR_JAL:  taken = 1'b1;
      BR_JR: begin
        taken  = 1'b1;
        target = reg_target;
      end
      default: taken = 1'b0;
    endcase
  end

  // Every redirect passes through FLUSH (even with FLUSH_CYCLES=1, counter
  // starts at 0) so redirects stay at least FLUSH_CYCLES+1 edges apart.
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pc_chg_q    <= 1'b0;
      pc_out_q    <= PC_INITIAL;
      flush_q     <= 1'b0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q    <= done_in;
      pc_chg_q  <= 1'b0;
      link_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && taken) begin
            pc_chg_q <= 1'b1;
            pc_out_q <= target;
            flush_q  <= 1'b1;
            cnt_q    <= 4'(FLUSH_CYCLES - 1);
            state_q  <= FLUSH;
            if (br_type == BR_JAL) begin
              link_we_q   <= 1'b1;
              link_data_q <= pc_in;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc_chg    = pc_chg_q;
  assign pc_out    = pc_out_q;
  assign flush     = flush_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus randomized traffic, checked
// against a cycle-level reference model built from the branch rules.
module tb_branch_resolve;

  localparam int unsigned PW = 16;
  localparam int unsigned OW = 12;
  localparam int unsigned FC = 2;

  logic          clk_in = 1'b0;
  logic          RST;
  logic          done_in, valid, flag_z, flag_n;
  logic [PW-1:0] pc_in, reg_target;
  logic [2:0]    br_type;
  logic [OW-1:0] offset;
  logic          pc_chg, flush, link_we, done;
  logic [PW-1:0] pc_out, link_data;

  branch_resolve #(
    .PC_WIDTH    (PW),
    .OFF_WIDTH   (OW),
    .PC_INITIAL  (16'h0000),
    .FLUSH_CYCLES(FC)
  ) dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .done_in   (done_in),
    .valid     (valid),
    .pc_in     (pc_in),
    .br_type   (br_type),
    .offset    (offset),
    .reg_target(reg_target),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .pc_chg    (pc_chg),
    .pc_out    (pc_out),
    .flush     (flush),
    .link_we   (link_we),
    .link_data (link_data),
    .done      (done)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic          m_pc_chg, m_flush, m_link_we, m_done;
  logic [PW-1:0] m_pc_out, m_link_data;
  int            m_left;  // flush cycles still to run after the current one

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_taken(input logic [2:0] bt, input logic z, input logic n);
    case (bt)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4, 3'd5, 3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [PW-1:0] rel_target(input logic [PW-1:0] pc, input logic [OW-1:0] off);
    int o;
    int s;
    o = int'(off);
    if (o >= (1 << (OW - 1))) o = o - (1 << OW);
    s = int'(pc) + o;
    return s[PW-1:0];
  endfunction

  task automatic model_reset();
    m_pc_chg = 0; m_flush = 0; m_link_we = 0; m_done = 0;
    m_pc_out = '0; m_link_data = '0; m_left = 0;
  endtask

  task automatic model_edge();
    m_done    = done_in;
    m_pc_chg  = 0;
    m_link_we = 0;
    if (m_left > 0) begin
      m_left--;
      m_flush = (m_left > 0);
    end else begin
      m_flush = 0;
      if (done_in && valid && is_taken(br_type, flag_z, flag_n)) begin
        m_pc_chg = 1;
        m_flush  = 1;
        m_left   = FC;
        m_pc_out = (br_type == 3'd6) ? reg_target : rel_target(pc_in, offset);
        if (br_type == 3'd5) begin
          m_link_we   = 1;
          m_link_data = pc_in;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc_chg"},    32'(pc_chg),    32'(m_pc_chg));
    chk({tag, ".pc_out"},    32'(pc_out),    32'(m_pc_out));
    chk({tag, ".flush"},     32'(flush),     32'(m_flush));
    chk({tag, ".link_we"},   32'(link_we),   32'(m_link_we));
    chk({tag, ".link_data"}, 32'(link_data), 32'(m_link_data));
    chk({tag, ".done"},      32'(done),      32'(m_done));
  endtask

  task automatic drive(input logic d, input logic v, input logic [PW-1:0] pc,
                       input logic [2:0] bt, input logic [OW-1:0] off,
                       input logic [PW-1:0] rt, input logic z, input logic n);
    done_in = d; valid = v; pc_in = pc; br_type = bt;
    offset = off; reg_target = rt; flag_z = z; flag_n = n;
  endtask

  task automatic tick(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle_ticks(input int n);
    drive(1, 0, '0, 3'd0, '0, '0, 0, 0);
    for (int i = 0; i < n; i++) tick("idle");
  endtask

  initial begin
    drive(0, 0, '0, 3'd0, '0, '0, 0, 0);
    RST = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    chk("reset.pc_out_const", 32'(pc_out), 32'h0000);
    #1 RST = 1'b1;

    drive(1, 0, '0, 3'd0, '0, '0, 0, 0);
    tick("first_done");
    chk("first_done.const", 32'(done), 32'h1);

    // BEQ taken: redirect, flush for FC cycles
    drive(1, 1, 16'h0010, 3'd1, 12'h005, '0, 1, 0);
    tick("beq_t");
    chk("beq_t.pc_out_const", 32'(pc_out), 32'h0015);
    chk("beq_t.pc_chg_const", 32'(pc_chg), 32'h1);
    drive(1, 0, '0, 3'd0, '0, '0, 0, 0);
    tick("beq_t_f1");
    chk("beq_t_f1.pc_chg_const", 32'(pc_chg), 32'h0);
    chk("beq_t_f1.flush_const", 32'(flush), 32'h1);
    tick("beq_t_f2");
    chk("beq_t_f2.flush_const", 32'(flush), 32'h0);

    // BEQ not taken
    drive(1, 1, 16'h0010, 3'd1, 12'h005, '0, 0, 0);
    tick("beq_nt");
    chk("beq_nt.pc_chg_const", 32'(pc_chg), 32'h0);

    // Wrap-around targets
    drive(1, 1, 16'h0001, 3'd4, 12'hFFE, '0, 0, 0);
    tick("jmp_wrap_neg");
    chk("jmp_wrap_neg.const", 32'(pc_out), 32'hFFFF);
    idle_ticks(2);
    drive(1, 1, 16'hFFFF, 3'd4, 12'h002, '0, 0, 0);
    tick("jmp_wrap_pos");
    chk("jmp_wrap_pos.const", 32'(pc_out), 32'h0001);
    idle_ticks(2);

    // JAL then JR
    drive(1, 1, 16'h0020, 3'd5, 12'h010, '0, 0, 0);
    tick("jal");
    chk("jal.pc_out_const", 32'(pc_out), 32'h0030);
    chk("jal.link_we_const", 32'(link_we), 32'h1);
    chk("jal.link_data_const", 32'(link_data), 32'h0020);
    idle_ticks(1);
    chk("jal.link_we_drop", 32'(link_we), 32'h0);
    idle_ticks(1);
    drive(1, 1, 16'h0040, 3'd6, 12'h000, 16'h1234, 0, 0);
    tick("jr");
    chk("jr.pc_out_const", 32'(pc_out), 32'h1234);
    chk("jr.link_we_const", 32'(link_we), 32'h0);
    idle_ticks(2);

    // done_in low blocks the instruction
    drive(0, 1, 16'h0100, 3'd4, 12'h011, '0, 0, 0);
    tick("done_low");
    chk("done_low.pc_chg_const", 32'(pc_chg), 32'h0);

    // Taken BNE during both flush cycles is ignored, accepted afterwards
    drive(1, 1, 16'h0200, 3'd4, 12'h020, '0, 0, 0);
    tick("pre_bne");
    drive(1, 1, 16'h0300, 3'd2, 12'h007, '0, 0, 0);
    tick("bne_ign1");
    chk("bne_ign1.pc_out_const", 32'(pc_out), 32'h0220);
    tick("bne_ign2");
    chk("bne_ign2.pc_chg_const", 32'(pc_chg), 32'h0);
    tick("bne_acc");
    chk("bne_acc.pc_out_const", 32'(pc_out), 32'h0307);
    idle_ticks(2);

    // Reset during first flush cycle, then BLT
    drive(1, 1, 16'h0400, 3'd4, 12'h001, '0, 0, 0);
    tick("pre_rst");
    drive(1, 0, '0, 3'd0, '0, '0, 0, 0);
    #1 RST = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    chk("mid_rst.flush_const", 32'(flush), 32'h0);
    #1 RST = 1'b1;
    drive(1, 1, 16'h0500, 3'd3, 12'h003, '0, 0, 1);
    tick("blt");
    chk("blt.pc_out_const", 32'(pc_out), 32'h0503);
    idle_ticks(2);

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7), PW'($urandom),
            3'($urandom_range(0, 7)), OW'($urandom), PW'($urandom),
            1'($urandom), 1'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        #1 RST = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        #1 RST = 1'b1;
      end
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
